// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ARRAY = 2'd1,
    RD_DONE  = 2'd2
  } dmem_state_e;

  localparam int DMEM_RD_LAT        = 2;
  localparam int DMEM_DEFAULT_DEPTH = 256;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH x DATA_W array, write-first, registered read data.
// Array contents are never reset; only the read-data register is.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter  int DEPTH  = DMEM_DEFAULT_DEPTH,
  parameter  int DATA_W = 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  // Read register updates only on a read so it holds between loads; write-first on collision.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= i_we ? i_wdata : r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory stage with a 2-cycle load FSM and single-cycle stores.
// Optional feature macro DMEM_ERR_EN: adds the sticky err output, suppresses
// out-of-range stores and returns 0 for out-of-range loads. Without it,
// addresses wrap modulo DEPTH.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEFAULT_DEPTH,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ReadData,
  output logic              stall
`ifdef DMEM_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e       r_state;
  dmem_state_e       w_next;
  logic [ADDR_W-1:0] r_addr_q;
  logic              w_issue_rd;
  logic              w_wr_req;
  logic              w_oor;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [DATA_W-1:0] w_ram_rdata;

  // A load is accepted only from IDLE and only when no store competes with it.
  assign w_issue_rd = (r_state == IDLE) && MemRead && !MemWrite;
  assign w_wr_req   = (r_state == IDLE) && MemWrite;

`ifdef DMEM_ERR_EN
  logic r_err;
  logic w_rd_oor;

  assign w_oor    = (addr >> IDX_W) != '0;
  assign w_rd_oor = (r_addr_q >> IDX_W) != '0;

  // Sticky error: out-of-range request or simultaneous read/write seen in IDLE.
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if ((r_state == IDLE) && (MemRead || MemWrite) && (w_oor || (MemRead && MemWrite)))
      r_err <= 1'b1;
  end

  assign err      = r_err;
  assign ReadData = w_rd_oor ? '0 : w_ram_rdata;
`else
  logic w_unused_hi;

  // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
  assign w_unused_hi = ^{addr, r_addr_q};
  assign w_oor       = 1'b0;
  assign ReadData    = w_ram_rdata;
`endif

  assign w_ram_we  = w_wr_req && !w_oor;
  assign w_ram_re  = (r_state == RD_ARRAY);
  assign w_ram_idx = (r_state == RD_ARRAY) ? r_addr_q[IDX_W-1:0] : addr[IDX_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and Mealy stall; RD_DONE always returns to IDLE so a held MemRead cannot retrigger.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemRead && !MemWrite) begin
          w_next = RD_ARRAY;
          stall  = 1'b1;
        end
      end
      RD_ARRAY: begin
        w_next = RD_DONE;
        stall  = 1'b1;
      end
      RD_DONE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Load address latch, captured when the load is accepted.
  always_ff @(posedge clk) begin
    if (rst)             r_addr_q <= '0;
    else if (w_issue_rd) r_addr_q <= addr;
  end

  dmem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_idx   (w_ram_idx),
    .i_wdata (wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl (DEPTH=16) against
// a transaction-level memory model. Honors DMEM_ERR_EN when defined.
module tb_dmem_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ReadData;
  logic              stall;
`ifdef DMEM_ERR_EN
  logic              err;
`endif

  dmem_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .ReadData (ReadData),
    .stall    (stall)
`ifdef DMEM_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: memory contents, last completed load value, sticky error.
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] rd_exp;
  logic              err_exp;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_oor(input int a);
`ifdef DMEM_ERR_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_err(input string tag);
`ifdef DMEM_ERR_EN
    chk(tag, 32'(err), 32'(err_exp));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with no request: no stall, ReadData held.
  task automatic idle_cycle();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_rdata", 32'(ReadData), 32'(rd_exp));
    chk_err("idle_err");
    tick();
  endtask

  // Store (optionally with MemRead also high): single cycle, never stalls.
  task automatic do_store(input int a, input logic [DATA_W-1:0] d, input bit both);
    MemWrite = 1'b1;
    MemRead  = both;
    addr     = ADDR_W'(a);
    wdata    = d;
    @(negedge clk);
    chk(both ? "both_stall" : "st_stall", 32'(stall), 32'd0);
    chk_err("st_err");
    if (!is_oor(a)) mem_m[a % DEPTH] = d;
`ifdef DMEM_ERR_EN
    if (is_oor(a) || both) err_exp = 1'b1;
`endif
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  // Load: stall in T and T+1, data valid in T+2. Optionally holds MemRead and
  // drives an illegal store during the stall, both of which must be ignored.
  task automatic do_load(input int a, input bit hold, input bit junk);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    addr     = ADDR_W'(a);
    @(negedge clk);
    chk("ld_t0_stall", 32'(stall), 32'd1);
    chk("ld_t0_rdata", 32'(ReadData), 32'(rd_exp));
    chk_err("ld_t0_err");
`ifdef DMEM_ERR_EN
    if (is_oor(a)) err_exp = 1'b1;
`endif
    tick();
    if (!hold) MemRead = 1'b0;
    if (junk) begin
      MemWrite = 1'b1;
      addr     = 8'($urandom);
      wdata    = 8'($urandom);
    end
    @(negedge clk);
    chk("ld_t1_stall", 32'(stall), 32'd1);
    chk_err("ld_t1_err");
    tick();
    rd_exp = is_oor(a) ? '0 : mem_m[a % DEPTH];
    @(negedge clk);
    chk("ld_t2_stall", 32'(stall), 32'd0);
    chk("ld_t2_rdata", 32'(ReadData), 32'(rd_exp));
    tick();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Reset asserted while the FSM is in RD_ARRAY abandons the load.
  task automatic load_with_reset(input int a);
    MemRead = 1'b1;
    addr    = ADDR_W'(a);
    @(negedge clk);
    chk("rstld_t0_stall", 32'(stall), 32'd1);
    tick();
    rst     = 1'b1;
    MemRead = 1'b0;
    @(negedge clk);
    chk("rstld_t1_stall", 32'(stall), 32'd1);
    tick();
    rst     = 1'b0;
    rd_exp  = '0;
    err_exp = 1'b0;
    @(negedge clk);
    chk("rstld_stall", 32'(stall), 32'd0);
    chk("rstld_rdata", 32'(ReadData), 32'd0);
    chk_err("rstld_err");
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    rd_exp   = '0;
    err_exp  = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", 32'(ReadData), 32'd0);
    chk_err("rst_err");
    tick();
    rst = 1'b0;

    // Give every location a known value.
    for (int i = 0; i < DEPTH; i++) do_store(i, 8'($urandom), 1'b0);

    // Store then load the same address on the next cycle.
    do_store(8'h10, 8'hA5, 1'b0);
    do_load(8'h10, 1'b0, 1'b0);

    // Back-to-back loads with MemRead held through the stall.
    do_store(8'h01, 8'h11, 1'b0);
    do_store(8'h02, 8'h22, 1'b0);
    do_load(8'h01, 1'b1, 1'b0);
    idle_cycle();
    do_load(8'h02, 1'b1, 1'b0);
    idle_cycle();

    // Store-to-load forwarding through the array.
    do_store(8'h05, 8'h3C, 1'b0);
    do_load(8'h05, 1'b0, 1'b0);

    // Reset mid-load; RAM contents must survive.
    do_store(8'h00, 8'hA5, 1'b0);
    load_with_reset(8'h10);
    do_load(8'h00, 1'b0, 1'b0);
    do_load(8'h10, 1'b0, 1'b0);

    // Upper address bits: wrap or out-of-range suppression.
    do_store(8'h03, 8'h5A, 1'b0);
    do_store(8'h13, 8'h77, 1'b0);
    do_load(8'h03, 1'b0, 1'b0);
    do_load(8'h13, 1'b0, 1'b0);

    // Simultaneous read/write performs the write only.
    do_store(8'h07, 8'hC3, 1'b1);
    idle_cycle();
    do_load(8'h07, 1'b0, 1'b1);

    // Randomized mix.
    for (int n = 0; n < 300; n++) begin
      int a;
      a = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(DEPTH - 1));
      case ($urandom_range(5))
        0, 1:    do_store(a, 8'($urandom), 1'b0);
        2, 3:    do_load(a, 1'($urandom), 1'($urandom));
        4:       do_store(a, 8'($urandom), 1'b1);
        default: idle_cycle();
      endcase
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory stage downstream of the datapath. Consumes the ALU result as the byte address and the second register-file read port as store data, and returns load data to the register-file write-back mux. Owns a synchronous-read 8-bit RAM and a small FSM that stalls the core for the two-cycle load latency. Stores complete in a single cycle without stalling.

## Interface
Parameters:
- DEPTH, 256: number of 8-bit words; power of two, 16..256.
- ADDR_W, 8: address width, matching the datapath ALU width.
- DATA_W, 8: word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from control; held while stall is high.
- MemWrite  in  1  store request from control.
- addr  in  ADDR_W  byte address, driven from ALUOut.
- wdata  in  DATA_W  store data, driven from rd2_Data.
- ReadData  out  DATA_W  load result to the MemToReg mux.
- stall  out  1  freezes PC and regfile write enable while high.
- err  out  1  sticky out-of-range flag; exists only with DMEM_ERR_EN.

## Operation
- FSM states: IDLE, RD_ARRAY, RD_DONE. Reset state is IDLE.
- IDLE:
  - MemWrite=1: RAM[addr] <= wdata at the edge. No stall; state stays IDLE.
  - MemRead=1 with MemWrite=0: latch addr into addr_q, raise stall combinationally, go to RD_ARRAY.
- RD_ARRAY: RAM[addr_q] is registered into rdata_q. stall=1. Go to RD_DONE.
- RD_DONE: stall=0. Core captures ReadData at the end of this cycle. Go to IDLE unconditionally, so a held MemRead does not retrigger.
- MemRead and MemWrite both high in IDLE:
  - The write is performed and the read is ignored.
  - err is set when DMEM_ERR_EN is defined.
- MemWrite in RD_ARRAY or RD_DONE is ignored. It cannot occur legally because the PC is frozen.
- ReadData = rdata_q. It holds its value until the next completed load.
- Address mapping: index = addr[$clog2(DEPTH)-1:0]. Upper bits are handled per Configuration.
- Reset does not clear RAM contents.

## Timing
- Load issued in cycle T (IDLE):
  - stall is high in T and T+1, low in T+2.
  - ReadData is valid from T+2 and stays stable after.
  - Load-to-use latency is 2 cycles.
- Store issued in cycle T: RAM is updated at the end of T. A load issued in T+1 to the same address returns the new data.
- stall is a Mealy output: stall = (state==IDLE && MemRead && !MemWrite) || state==RD_ARRAY.
- Reset values: state=IDLE, stall=0, ReadData=0 (rdata_q=0), addr_q=0, err=0.
- Reset asserted mid-load: the FSM returns to IDLE at the next edge, stall drops, ReadData=0, and the load is abandoned.

## Configuration
- DMEM_ERR_EN defined:
  - err port present.
  - err sets on any request with nonzero addr bits above $clog2(DEPTH), or on simultaneous MemRead/MemWrite.
  - An out-of-range store is suppressed. An out-of-range load returns 0 and still takes 2 cycles.
  - err clears only on rst.
- DMEM_ERR_EN undefined: no err port, and addresses wrap modulo DEPTH.

## Structure
- Shared package dmem_pkg holds:
  - the state enum typedef (IDLE, RD_ARRAY, RD_DONE), 2-bit encoding;
  - constants DMEM_RD_LAT=2 and DMEM_DEFAULT_DEPTH=256.
- One sub-module, dmem_ram: DEPTH×DATA_W array with a single port, write-first, and registered read data.
- dmem_ctrl contains the FSM, the address latch, stall generation and the err logic.

## Test plan
- Reset, then store 0xA5 to addr 0x10. Next cycle issue a load from 0x10. Expect stall=1 for 2 cycles, then ReadData=0xA5 with stall=0.
- Back-to-back loads from 0x01 (holding 0x11) and 0x02 (holding 0x22), MemRead held through the stall. Expect ReadData=0x11, then one IDLE cycle, then 0x22; no retrigger on the held MemRead.
- Store to 0x05, then a load from 0x05 in the immediately following cycle. Expect the new data returned.
- Assert rst in RD_ARRAY. Expect stall=0 and ReadData=0 after the edge, and RAM[0x10] still 0xA5 on a later load.
- DEPTH=16 with DMEM_ERR_EN: store 0x77 to addr 0x13. Expect err=1 and RAM[3] unchanged. A load from 0x13 returns 0.
- DEPTH=16 without the macro: store 0x77 to 0x13, then load from 0x03. Expect 0x77 (wrap). Simultaneous MemRead/MemWrite performs the write with no stall.
